dq_quadword_sequencer: RTL

- Sits between the DQ-format decode stage and the load/store unit.
- Takes one decoded quadword memory op at a time: lq, lxv or stxv.
- Splits it into two ordered doubleword beats to the load/store unit, using a valid/ready handshake on that side.
- Rejects illegal lq register forms before any beat is issued.

---
 rtl/dq_quadword_sequencer_pkg.sv | 35 +++
 rtl/dq_quadword_sequencer_if.sv | 50 +++++
 rtl/dq_quadword_sequencer_offset_gen.sv | 21 ++
 rtl/dq_quadword_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dq_quadword_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dq_quadword_sequencer_pkg
// Shared constants for the DQ-form quadword sequencer:
//   - functional unit codes (the sequencer only accepts the load/store code)
//   - register-use codes for the decoded operand classes
//   - sequencer state encoding
//   - doubleword stride between the two beats of a quadword access
// ---------------------------------------------------------------------------
package dq_quadword_sequencer_pkg;

   localparam logic [2:0] FXUnitCode   = 3'd0;
   localparam logic [2:0] FPUnitCode   = 3'd1;
   localparam logic [2:0] LdStUnitCode = 3'd2;
   localparam logic [2:0] BrUnitCode   = 3'd3;
   localparam logic [2:0] CRUnitCode   = 3'd4;
   localparam logic [2:0] SysUnitCode  = 3'd5;
   localparam logic [2:0] TrapUnitCode = 3'd6;

   typedef enum logic [1:0] {
      REG_USE_NONE     = 2'd0,
      REG_USE_GPR      = 2'd1,
      REG_USE_GPR_PAIR = 2'd2,
      REG_USE_VSR      = 2'd3
   } reg_use_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } seq_state_e;

   // Byte distance between the high and low doubleword of a quadword.
   localparam int DW_STRIDE = 8;

endpackage

// File: rtl/dq_quadword_sequencer_if.sv
// ---------------------------------------------------------------------------
// dq_quadword_sequencer_if
// Bundles the decode-side op inputs and the load/store-side beat outputs.
//   slave  : the sequencer's view (decode fields in, beats out)
//   master : the environment's view (decode fields out, beats in)
// Handshake: a beat transfers on a rising edge where enable_o = 1 and
// ldstReady_i = 1; while enable_o = 1 and ldstReady_i = 0 the payload
// (regData_o, regBase_o, offset_o, half_o, isStore_o) is held unchanged.
// On the decode side an op is taken on a rising edge where enable_i = 1 and
// stall_o = 0; upstream must hold the op while stall_o = 1.
// dbg_state_o mirrors the sequencer state (0 IDLE, 1 BEAT0, 2 BEAT1).
// ---------------------------------------------------------------------------
interface dq_quadword_sequencer_if #(
   parameter int regWidth = 5,
   parameter int dqWidth  = 12,
   parameter int immWidth = 16
);
   logic                enable_i;
   logic [2:0]          functionalUnitCode_i;
   logic                isStore_i;
   logic                isVsx_i;
   logic [regWidth-1:0] reg1_i;
   logic [regWidth-1:0] reg2_i;
   logic                bit_i;
   logic [dqWidth-1:0]  imm_i;
   logic                stall_o;
   logic                enable_o;
   logic                ldstReady_i;
   logic [regWidth:0]   regData_o;
   logic [regWidth-1:0] regBase_o;
   logic [immWidth-1:0] offset_o;
   logic                half_o;
   logic                isStore_o;
   logic                illegal_o;
   logic [1:0]          dbg_state_o;

   modport slave (
      input  enable_i, functionalUnitCode_i, isStore_i, isVsx_i, reg1_i,
             reg2_i, bit_i, imm_i, ldstReady_i,
      output stall_o, enable_o, regData_o, regBase_o, offset_o, half_o,
             isStore_o, illegal_o, dbg_state_o
   );

   modport master (
      output enable_i, functionalUnitCode_i, isStore_i, isVsx_i, reg1_i,
             reg2_i, bit_i, imm_i, ldstReady_i,
      input  stall_o, enable_o, regData_o, regBase_o, offset_o, half_o,
             isStore_o, illegal_o, dbg_state_o
   );
endinterface

// File: rtl/dq_quadword_sequencer_offset_gen.sv
// ---------------------------------------------------------------------------
// dq_offset_gen
// Combinational byte-offset generator for DQ-form quadword accesses.
//   i_imm : raw DQ field (dqWidth bits, signed, units of 16 bytes)
//   o_d   : D = sign_extend(DQ || 0b0000), immWidth bits (high doubleword)
//   o_d8  : D + DW_STRIDE (low doubleword); D tops out at 32752 so the
//           add never wraps for the default widths
// ---------------------------------------------------------------------------
module dq_offset_gen
   import dq_quadword_sequencer_pkg::*;
#(
   parameter int dqWidth  = 12,
   parameter int immWidth = 16
) (
   input  logic [dqWidth-1:0]  i_imm,
   output logic [immWidth-1:0] o_d,
   output logic [immWidth-1:0] o_d8
);
   assign o_d  = immWidth'($signed({i_imm, 4'b0000}));
   assign o_d8 = o_d + immWidth'(DW_STRIDE);
endmodule

// File: rtl/dq_quadword_sequencer.sv
// ---------------------------------------------------------------------------
// dq_quadword_sequencer
// Splits one decoded quadword op (lq, lxv, stxv) into two ordered doubleword
// beats to the load/store unit: beat 0 = high doubleword (offset D),
// beat 1 = low doubleword (offset D + 8).
// Ports:
//   clock_i  : clock
//   reset_i  : synchronous active-high reset (aborts any op in flight)
//   bus      : dq_quadword_sequencer_if.slave (decode fields, stall_o,
//              beat payload, enable_o/ldstReady_i handshake, illegal_o,
//              dbg_state_o)
// Build option: define DQ_ILLEGAL_FORM_CHECK_EN to reject lq with odd RT or
// RT == RA (illegal_o pulses, no beats). Without it every lq issues beats.
// ---------------------------------------------------------------------------
module dq_quadword_sequencer
   import dq_quadword_sequencer_pkg::*;
#(
   parameter int         regWidth     = 5,
   parameter int         dqWidth      = 12,
   parameter int         immWidth     = 16,
   parameter logic [2:0] LdStUnitCode = dq_quadword_sequencer_pkg::LdStUnitCode
) (
   input logic                   clock_i,
   input logic                   reset_i,
   dq_quadword_sequencer_if.slave bus
);
   seq_state_e          r_state;
   seq_state_e          w_state_nxt;
   logic                w_accept;
   logic                w_illegal_form;
   logic [immWidth-1:0] w_off0;
   logic [immWidth-1:0] w_off1;
   logic [regWidth:0]   w_data0;
   logic [regWidth:0]   w_data1;

   logic [regWidth:0]   r_reg_data;
   logic [regWidth:0]   r_reg_data1;   // beat-1 register held during beat 0
   logic [regWidth-1:0] r_reg_base;
   logic [immWidth-1:0] r_offset;
   logic [immWidth-1:0] r_offset1;     // beat-1 offset held during beat 0
   logic                r_half;
   logic                r_is_store;
   logic                r_illegal;

   dq_offset_gen #(
      .dqWidth  (dqWidth),
      .immWidth (immWidth)
   ) u_offset_gen (
      .i_imm (bus.imm_i),
      .o_d   (w_off0),
      .o_d8  (w_off1)
   );

   always_comb begin
      w_accept = bus.enable_i && (bus.functionalUnitCode_i == LdStUnitCode)
                 && (r_state == IDLE);
`ifdef DQ_ILLEGAL_FORM_CHECK_EN
      w_illegal_form = !bus.isVsx_i
                       && (bus.reg1_i[0] || (bus.reg1_i == bus.reg2_i));
`else
      w_illegal_form = 1'b0;
`endif
      // lq targets the GPR pair RT, RT+1; VSX ops hit one VSR twice.
      if (bus.isVsx_i) begin
         w_data0 = {bus.bit_i, bus.reg1_i};
         w_data1 = {bus.bit_i, bus.reg1_i};
      end else begin
         w_data0 = {1'b0, bus.reg1_i};
         w_data1 = {1'b0, bus.reg1_i + regWidth'(1)};
      end

      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_illegal_form) w_state_nxt = BEAT0;
         BEAT0:   if (bus.ldstReady_i) w_state_nxt = BEAT1;
         BEAT1:   if (bus.ldstReady_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state     <= IDLE;
         r_reg_data  <= '0;
         r_reg_data1 <= '0;
         r_reg_base  <= '0;
         r_offset    <= '0;
         r_offset1   <= '0;
         r_half      <= 1'b0;
         r_is_store  <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_illegal <= w_accept && w_illegal_form;
         if (w_accept && !w_illegal_form) begin
            r_reg_data  <= w_data0;
            r_reg_data1 <= w_data1;
            r_reg_base  <= bus.reg2_i;
            r_offset    <= w_off0;
            r_offset1   <= w_off1;
            r_half      <= 1'b0;
            r_is_store  <= bus.isStore_i;
         end else if ((r_state == BEAT0) && bus.ldstReady_i) begin
            r_reg_data <= r_reg_data1;
            r_offset   <= r_offset1;
            r_half     <= 1'b1;
         end
      end
   end

   assign bus.stall_o     = (r_state != IDLE);
   assign bus.enable_o    = (r_state == BEAT0) || (r_state == BEAT1);
   assign bus.regData_o   = r_reg_data;
   assign bus.regBase_o   = r_reg_base;
   assign bus.offset_o    = r_offset;
   assign bus.half_o      = r_half;
   assign bus.isStore_o   = r_is_store;
   assign bus.illegal_o   = r_illegal;
   assign bus.dbg_state_o = r_state;
endmodule
